// File: rtl/crypto_defs.sv
// Shared definitions for the key/block RAM read and write paths:
// default geometry, FSM state encoding and the host word-swap index.
package crypto_defs;

    localparam int unsigned DEF_WORDS     = 32'd4;
    localparam int unsigned DEF_WORD_SIZE = 32'd32;
    localparam int unsigned BLOCK_SIZE    = DEF_WORD_SIZE * DEF_WORDS;
    localparam int unsigned WORD_BYTES    = DEF_WORD_SIZE / 32'd8;

    // Block holder state: EMPTY means nothing unread is held.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rd_state_e;

    // Host word k lives in storage word slot words-1-k, so host index 0 is
    // the most-significant word. The write-side RAM uses the same mapping.
    function automatic int unsigned wsel(input int unsigned k, input int unsigned words);
        return words - 32'd1 - k;
    endfunction

endpackage

// File: rtl/block_reader_word_sel.sv
// Combinational swapped word mux: selects host word idx from a packed
// block, returning zero for an index past the last word.
module block_word_sel
    import crypto_defs::*;
#(
    parameter int unsigned WORDS     = DEF_WORDS,
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic [WORD_SIZE*WORDS-1:0]  block,
    input  logic [$clog2(WORDS)-1:0]    idx,
    output logic [WORD_SIZE-1:0]        word
);

    localparam int unsigned IDX_W = $clog2(WORDS);

    // OR together every slot, each masked by whether it is the addressed one.
    always_comb begin
        word = {WORD_SIZE{1'b0}};
        for (int k = 0; k < WORDS; k++) begin
            word = word | (block[wsel(k, WORDS)*WORD_SIZE +: WORD_SIZE]
                           & {WORD_SIZE{idx == IDX_W'(k)}});
        end
    end

endmodule

// File: rtl/block_reader.sv
// block_reader: holds one cipher output block and serves it to the host a
// word at a time, tracking which words were read and flagging completion.
// Optional build macro READ_CLEAR_EN: reads in FULL also wipe the word read.
module block_reader
    import crypto_defs::*;
#(
    parameter int unsigned WORDS     = DEF_WORDS,
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [WORD_SIZE*WORDS-1:0]  block_in,
    input  logic [$clog2(WORDS)-1:0]    ridx,
    input  logic                        ren,
    input  logic                        ovf_clr,
    output logic [WORD_SIZE-1:0]        rdata,
    output logic                        rvalid,
    output logic                        full,
    output logic                        done,
    output logic                        overflow,
    output logic [WORDS-1:0]            read_mask
);

    localparam int unsigned IDX_W   = $clog2(WORDS);
    localparam int unsigned BLOCK_W = WORD_SIZE * WORDS;

    rd_state_e              state_r;
    logic [BLOCK_W-1:0]     storage_r;
    logic [WORD_SIZE-1:0]   rdata_r;
    logic                   rvalid_r;
    logic                   full_r;
    logic                   done_r;
    logic                   overflow_r;
    logic [WORDS-1:0]       read_mask_r;

    logic [WORD_SIZE-1:0]   rd_word_s;
    logic                   in_range_s;
    logic [WORDS-1:0]       mask_set_s;
    logic                   mask_done_s;

    block_word_sel #(
        .WORDS     (WORDS),
        .WORD_SIZE (WORD_SIZE)
    ) u_word_sel (
        .block (storage_r),
        .idx   (ridx),
        .word  (rd_word_s)
    );

    // An index can only be out of range when WORDS is not a power of two.
    generate
        if ((32'd1 << IDX_W) == WORDS) begin : g_pow2
            assign in_range_s = 1'b1;
        end else begin : g_npow2
            assign in_range_s = (32'(ridx) < 32'(WORDS));
        end
    endgenerate

    // Mask as it would be after marking the addressed word as read.
    always_comb begin
        mask_set_s  = read_mask_r
                    | (({{(WORDS-1){1'b0}}, 1'b1} << ridx) & {WORDS{in_range_s}});
        mask_done_s = (mask_set_s == {WORDS{1'b1}});
    end

`ifdef READ_CLEAR_EN
    logic [BLOCK_W-1:0] storage_clr_s;

    // Storage with the addressed host word zeroed, used on reads in FULL.
    always_comb begin
        storage_clr_s = storage_r;
        for (int k = 0; k < WORDS; k++) begin
            storage_clr_s[wsel(k, WORDS)*WORD_SIZE +: WORD_SIZE] =
                storage_r[wsel(k, WORDS)*WORD_SIZE +: WORD_SIZE]
                & ~{WORD_SIZE{in_range_s && (ridx == IDX_W'(k))}};
        end
    end
`endif

    // Holder FSM with registered read port, mask, completion and overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            storage_r   <= {BLOCK_W{1'b0}};
            rdata_r     <= {WORD_SIZE{1'b0}};
            rvalid_r    <= 1'b0;
            full_r      <= 1'b0;
            done_r      <= 1'b0;
            overflow_r  <= 1'b0;
            read_mask_r <= {WORDS{1'b0}};
        end else begin
            // Read port: always answers from the pre-edge storage contents.
            rvalid_r <= ren;
            done_r   <= 1'b0;
            if (ren) begin
                rdata_r <= rd_word_s;
            end

            // Overflow is sticky; an overflowing load beats a clear.
            if (load && full_r) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end

            if (load) begin
                // Load wins over any concurrent read bookkeeping.
                storage_r   <= block_in;
                read_mask_r <= {WORDS{1'b0}};
                full_r      <= 1'b1;
                state_r     <= ST_FULL;
            end else begin
                case (state_r)
                    ST_EMPTY: begin
                        full_r <= 1'b0;
                    end
                    ST_FULL: begin
                        if (ren && in_range_s) begin
                            read_mask_r <= mask_set_s;
`ifdef READ_CLEAR_EN
                            storage_r   <= storage_clr_s;
`else
                            storage_r   <= storage_r;
`endif
                            if (mask_done_s) begin
                                done_r  <= 1'b1;
                                full_r  <= 1'b0;
                                state_r <= ST_EMPTY;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_EMPTY;
                        full_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rdata     = rdata_r;
    assign rvalid    = rvalid_r;
    assign full      = full_r;
    assign done      = done_r;
    assign overflow  = overflow_r;
    assign read_mask = read_mask_r;

endmodule

// File: tb/tb_block_reader.sv
// Self-checking bench for block_reader: directed steps from the test plan
// followed by random traffic, all compared against a word-array model.
module tb_block_reader;

    localparam int WORDS = 4;
    localparam int WS    = 32;

    logic               clk;
    logic               rst_n;
    logic               load;
    logic [WS*WORDS-1:0] block_in;
    logic [1:0]         ridx;
    logic               ren;
    logic               ovf_clr;
    logic [WS-1:0]      rdata;
    logic               rvalid;
    logic               full;
    logic               done;
    logic               overflow;
    logic [WORDS-1:0]   read_mask;

    int checks = 0;
    int errors = 0;

    // Reference model: host-ordered word array plus per-word read flags.
    logic [WS-1:0] m_words [WORDS];
    bit            m_read  [WORDS];
    bit            m_full, m_ovf, m_done, m_rvalid;
    logic [WS-1:0] m_rdata;

    block_reader #(.WORDS(WORDS), .WORD_SIZE(WS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .block_in  (block_in),
        .ridx      (ridx),
        .ren       (ren),
        .ovf_clr   (ovf_clr),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .full      (full),
        .done      (done),
        .overflow  (overflow),
        .read_mask (read_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_mask();
        logic [3:0] m;
        for (int i = 0; i < WORDS; i++) m[i] = m_read[i];
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < WORDS; i++) begin
            m_words[i] = '0;
            m_read[i]  = 1'b0;
        end
        m_full = 0; m_ovf = 0; m_done = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    // One clock edge of the specified behaviour, expressed on whole words.
    task automatic model_step(input bit ld, input logic [127:0] blk, input bit rd,
                              input int idx, input bit clr);
        bit all;
        m_rvalid = rd;
        m_done   = 0;
        if (rd) m_rdata = m_words[idx];
        if (ld && m_full) m_ovf = 1;
        else if (clr)     m_ovf = 0;
        if (ld) begin
            // Host word k is the k-th 32-bit group counting from the top.
            for (int k = 0; k < WORDS; k++) m_words[k] = 32'(blk >> (WS * (WORDS - 1 - k)));
            for (int k = 0; k < WORDS; k++) m_read[k] = 0;
            m_full = 1;
        end else if (rd && m_full) begin
            m_read[idx] = 1;
`ifdef READ_CLEAR_EN
            m_words[idx] = '0;
`endif
            all = 1;
            for (int k = 0; k < WORDS; k++) all &= m_read[k];
            if (all) begin
                m_done = 1;
                m_full = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rdata"},    rdata,            m_rdata);
        chk({tag, ".rvalid"},   32'(rvalid),      32'(m_rvalid));
        chk({tag, ".full"},     32'(full),        32'(m_full));
        chk({tag, ".done"},     32'(done),        32'(m_done));
        chk({tag, ".overflow"}, 32'(overflow),    32'(m_ovf));
        chk({tag, ".mask"},     32'(read_mask),   32'(m_mask()));
    endtask

    task automatic cycle(input string tag, input bit ld, input logic [127:0] blk,
                         input bit rd, input int idx, input bit clr);
        load = ld; block_in = blk; ren = rd; ridx = 2'(idx); ovf_clr = clr;
        @(posedge clk);
        model_step(ld, blk, rd, idx, clr);
        #1;
        check_all(tag);
        load = 0; ren = 0; ovf_clr = 0;
    endtask

    initial begin
        logic [127:0] blk1, ba, bb, bc;
        logic [31:0]  exp1 [4];
        logic [3:0]   oo_mask [5];
        int           oo_idx [5];
        blk1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        exp1 = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        oo_idx  = '{2, 0, 2, 3, 1};
        oo_mask = '{4'b0100, 4'b0101, 4'b0101, 4'b1101, 4'b1111};

        rst_n = 0; load = 0; block_in = '0; ren = 0; ridx = '0; ovf_clr = 0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1;

        // In-order read of the reference block.
        cycle("load1", 1, blk1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle("seq", 0, '0, 1, i, 0);
            chk("seq.word", rdata, exp1[i]);
        end
        chk("seq.done_last", 32'(done), 32'd1);
        chk("seq.full_after", 32'(full), 32'd0);

        // Out-of-order reads with a repeat.
        cycle("load2", 1, blk1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle("ooo", 0, '0, 1, oo_idx[i], 0);
            chk("ooo.mask_lit", 32'(read_mask), 32'(oo_mask[i]));
            chk("ooo.done_lit", 32'(done), (i == 4) ? 32'd1 : 32'd0);
        end

        // Overflow set, clear, and set-beats-clear.
        ba = {$urandom, $urandom, $urandom, $urandom};
        bb = {$urandom, $urandom, $urandom, $urandom};
        bc = {$urandom, $urandom, $urandom, $urandom};
        cycle("ovf.loadA", 1, ba, 0, 0, 0);
        cycle("ovf.rd0",   0, '0, 1, 0, 0);
        cycle("ovf.loadB", 1, bb, 0, 0, 0);
        chk("ovf.set", 32'(overflow), 32'd1);
        chk("ovf.mask0", 32'(read_mask), 32'd0);
        cycle("ovf.rdB",   0, '0, 1, 0, 0);
        chk("ovf.Bword", rdata, bb[127:96]);
        cycle("ovf.clr",   0, '0, 0, 0, 1);
        chk("ovf.cleared", 32'(overflow), 32'd0);
        cycle("ovf.setwin", 1, bc, 0, 0, 1);
        chk("ovf.setwins", 32'(overflow), 32'd1);

        // Same-cycle load and read: old word returned, load wins.
        cycle("lr.loadA", 1, ba, 0, 0, 0);
        cycle("lr.both",  1, bb, 1, 3, 0);
        chk("lr.oldword", rdata, ba[31:0]);
        chk("lr.mask", 32'(read_mask), 32'd0);
        chk("lr.full", 32'(full), 32'd1);
        chk("lr.nodone", 32'(done), 32'd0);

        // Read everything, then re-read word 1.
        cycle("rc.load", 1, blk1, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle("rc.rd", 0, '0, 1, i, 0);
        cycle("rc.reread", 0, '0, 1, 1, 0);
`ifdef READ_CLEAR_EN
        chk("rc.lit", rdata, 32'h0);
`else
        chk("rc.lit", rdata, 32'h44556677);
`endif

        // Asynchronous reset between edges with reads in flight.
        cycle("mr.load", 1, blk1, 0, 0, 0);
        load = 0; ren = 1; ridx = 2'd3;
        @(posedge clk);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_all("mr.async");
        @(negedge clk);
        rst_n = 1;
        cycle("mr.rd", 0, '0, 1, 2, 0);
        chk("mr.zero", rdata, 32'h0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cycle("rand", ($urandom_range(0, 7) == 0),
                  {$urandom, $urandom, $urandom, $urandom},
                  ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
